btn_debounce_multi: RTL and testbench
=====================================

Name: btn_debounce_multi

Overview:
- Multi-channel, parametrised push-button conditioner for board-level inputs such as buttons and switches feeding FSMs and SPI control logic.
- Per channel, it provides:
  - 2-FF input synchronisation
  - tick-sampled shift-register debounce with hysteresis
  - a debounced level output
  - one-clock rise and fall pulses
  - a long-press pulse with optional auto-repeat
- One shared tick generator serves all channels; everything runs in the single `clk` domain.

Parameters:
- NUM_CH, 4, number of independent button channels (≥1)
- CLK_DIV, 100, clk cycles per sample tick (≥2)
- DEPTH, 8, samples that must agree before the debounced level changes (≥2)
- HOLD_TICKS, 1000, ticks of stable high before `o_hold` fires (≥1)
- REPEAT_TICKS, 0, ticks between `o_hold` repeats after the first; 0 disables repeat

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- i_btn  in  NUM_CH  raw asynchronous button inputs, active-high
- i_en  in  1  sampling enable; when 0, ticks are suppressed and all state holds
- o_level  out  NUM_CH  debounced level
- o_rise  out  NUM_CH  one-clk pulse on debounced 0→1
- o_fall  out  NUM_CH  one-clk pulse on debounced 1→0
- o_hold  out  NUM_CH  one-clk pulse on long press and on each repeat
- o_tick  out  1  sample strobe, for debug and verification

Behaviour:
- **Reset:** reset is synchronous to `clk`, active-high, and overrides everything. All registers clear to 0: synchronisers, tick counter, shift registers, levels, hold counters and pulse outputs. Reset mid-press returns `o_level` to 0 with no `o_fall` pulse.
- **Tick generator:**
  - Counter width is `$clog2(CLK_DIV)`.
  - The counter runs 0..CLK_DIV-1 and wraps to 0.
  - `o_tick` = 1 for exactly one clk cycle when counter == CLK_DIV-1 and `i_en` = 1.
  - When `i_en` = 0, the counter holds its value and `o_tick` = 0.
  - The tick is a clock enable, never a derived clock.
- **Synchroniser:** per channel, a 2-FF chain on `i_btn`. Its output `s` lags `i_btn` by 2 clk.
- **Shift register:** DEPTH bits per channel. On a tick, it shifts in `s` at the MSB and drops the LSB.
- **Debounced level (hysteresis):**
  - Next-cycle level = 1 if all DEPTH bits are 1.
  - Next-cycle level = 0 if all DEPTH bits are 0.
  - Otherwise the level holds.
  - Mixed patterns never toggle the level.
- **Edge pulses:**
  - `o_rise` = level & ~level_d.
  - `o_fall` = ~level & level_d.
  - `level_d` is `o_level` delayed by one clk.
  - Each pulse is exactly one clk wide, regardless of CLK_DIV.
- **Latency:** from a clean `i_btn` step to the `o_level` change is 2 clk (sync) plus up to DEPTH ticks, plus 1 clk. The rise/fall pulse appears in the same cycle as the `o_level` change.
- **Long-press FSM, per channel.** States:
  - IDLE: level=0.
  - PRESS: counting toward HOLD_TICKS.
  - REPEAT: counting toward REPEAT_TICKS.
  - DONE: REPEAT_TICKS = 0 and hold already fired.
- **FSM transitions:**
  - IDLE → PRESS on `o_rise`; hold counter cleared.
  - PRESS: on each tick, counter += 1. When counter reaches HOLD_TICKS, pulse `o_hold` for 1 clk, clear the counter, then go to REPEAT if REPEAT_TICKS > 0, else DONE.
  - REPEAT: on each tick, counter += 1. At REPEAT_TICKS, pulse `o_hold` and clear the counter.
  - Any state → IDLE when level = 0, within 1 clk of `o_fall`. A release in the same cycle as the hold threshold suppresses `o_hold`; release wins.
- **Counter width and saturation:** hold counter width is `$clog2(max(HOLD_TICKS, REPEAT_TICKS) + 1)`. It never wraps; DONE holds it.
- **Channel independence:** channels are fully independent. Simultaneous events on multiple channels yield simultaneous pulses.
- **Enable:** `i_en` = 0 freezes the shift registers and hold counters. The synchronisers keep running, and pulses already in flight still complete.

Decomposition:
- Package `btn_debounce_pkg`:
  - `hold_state_e` enum: IDLE, PRESS, REPEAT, DONE.
  - Helper function `cnt_w(n)`, returning `$clog2(n+1)` with a minimum of 1.
- Sub-module `btn_debounce_ch`:
  - One channel: synchroniser, shift register, level, edges and hold FSM.
  - Inputs: clk, rst, tick, btn. Outputs: level, rise, fall, hold.
- Top level: tick generator plus a `generate` loop of NUM_CH instances.

Test Plan (sim parameters: NUM_CH=2, CLK_DIV=4, DEPTH=4, HOLD_TICKS=8, REPEAT_TICKS=4):
- **Clean press, ch0:** i_btn[0] 0→1 held, `i_en`=1.
  - `o_tick` every 4th clk.
  - `o_level[0]` rises no more than 2+16+1 clk after the step.
  - `o_rise[0]` is a single 1-clk pulse; ch1 outputs stay 0.
- **Bounce:**
  - i_btn[0] toggles every 3 clk for 40 clk, then stays at 1 → exactly one `o_rise`, no `o_fall`.
  - Same bounce on release → exactly one `o_fall`.
- **Long press with repeat:** hold ch1 high for 100 ticks → `o_hold[1]` at 8 ticks after rise, then every 4 ticks (23 pulses); on release, `o_fall[1]` and no further `o_hold`.
- **Release at threshold:** release timed so level falls on the tick that would reach count 8 → no `o_hold`; FSM returns to IDLE.
- **Reset mid-press:** assert `rst` for 1 clk while `o_level[0]`=1 → all outputs 0 on the next clk, no `o_fall`; re-press yields normal debounce timing from scratch.
- **Enable freeze:** drop `i_en` for 20 clk during PRESS → no ticks and no counter advance; on re-enable, `o_hold` arrives 20 clk later than in the baseline run.

Source files
------------

// File: rtl/btn_debounce_pkg.sv
// Shared types and helpers for the multi-channel button debouncer.
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRESS  = 2'd1,
    REPEAT = 2'd2,
    DONE   = 2'd3
  } hold_state_e;

  // Bits needed to hold values 0..n, never less than one.
  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, tick-sampled shift debounce with
// hysteresis, edge pulses and long-press / auto-repeat FSM.
//
// state  | meaning
// IDLE   | debounced level low, nothing counting
// PRESS  | level high, counting ticks toward the first hold pulse
// REPEAT | first hold fired, counting ticks toward the next repeat
// DONE   | hold fired and repeat disabled; counter parked until release
module btn_debounce_ch
  import btn_debounce_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int HOLD_TICKS   = 1000,
  parameter int REPEAT_TICKS = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn,
  output logic level,
  output logic rise,
  output logic fall,
  output logic hold
);

  localparam int CW = cnt_w((HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS);
  localparam logic [CW-1:0] HOLD_C = CW'(HOLD_TICKS);
  localparam logic [CW-1:0] REP_C  = CW'(REPEAT_TICKS);

  logic             sync_q1;
  logic             sync_q2;
  logic [DEPTH-1:0] shift_q;
  logic             level_d;
  hold_state_e      state;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_inc;

  assign cnt_inc = cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      shift_q <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
      if (tick) begin
        shift_q <= {sync_q2, shift_q[DEPTH-1:1]};
      end
      // Mixed sample windows leave the level where it is.
      if (&shift_q) begin
        level <= 1'b1;
      end else if (~|shift_q) begin
        level <= 1'b0;
      end
      level_d <= level;
    end
  end

  assign rise = level & ~level_d;
  assign fall = ~level & level_d;

  // Release is checked first so a drop on the threshold tick suppresses hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      hold  <= 1'b0;
    end else begin
      hold <= 1'b0;
      if (!level) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              state <= PRESS;
              cnt   <= '0;
            end
          end
          PRESS: begin
            if (tick) begin
              if (cnt_inc == HOLD_C) begin
                hold  <= 1'b1;
                cnt   <= '0;
                state <= (REPEAT_TICKS > 0) ? REPEAT : DONE;
              end else begin
                cnt <= cnt_inc;
              end
            end
          end
          REPEAT: begin
            if (tick) begin
              if (cnt_inc == REP_C) begin
                hold <= 1'b1;
                cnt  <= '0;
              end else begin
                cnt <= cnt_inc;
              end
            end
          end
          DONE: begin
            cnt <= cnt;
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/btn_debounce_multi.sv
// Multi-channel button conditioner: one shared sample-tick generator used as
// a clock enable by NUM_CH independent debounce channels.
module btn_debounce_multi
  import btn_debounce_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CLK_DIV      = 100,
  parameter int DEPTH        = 8,
  parameter int HOLD_TICKS   = 1000,
  parameter int REPEAT_TICKS = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] i_btn,
  input  logic              i_en,
  output logic [NUM_CH-1:0] o_level,
  output logic [NUM_CH-1:0] o_rise,
  output logic [NUM_CH-1:0] o_fall,
  output logic [NUM_CH-1:0] o_hold,
  output logic              o_tick
);

  localparam int TW = $clog2(CLK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);

  logic [TW-1:0] tick_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (i_en) begin
      tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
    end
  end

  assign o_tick = i_en & ~rst & (tick_cnt == TICK_LAST);

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      btn_debounce_ch #(
        .DEPTH        (DEPTH),
        .HOLD_TICKS   (HOLD_TICKS),
        .REPEAT_TICKS (REPEAT_TICKS)
      ) u_ch (
        .clk   (clk),
        .rst   (rst),
        .tick  (o_tick),
        .btn   (i_btn[g]),
        .level (o_level[g]),
        .rise  (o_rise[g]),
        .fall  (o_fall[g]),
        .hold  (o_hold[g])
      );
    end
  endgenerate

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Directed bench for btn_debounce_multi with a per-cycle reference model.
module tb_btn_debounce_multi;

  localparam int NCH  = 2;
  localparam int CDIV = 4;
  localparam int DEP  = 4;
  localparam int HOLD = 8;
  localparam int REP  = 4;

  logic           clk   = 1'b0;
  logic           rst   = 1'b1;
  logic           i_en  = 1'b1;
  logic [NCH-1:0] i_btn = '0;
  logic [NCH-1:0] o_level, o_rise, o_fall, o_hold;
  logic           o_tick;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  btn_debounce_multi #(
    .NUM_CH(NCH), .CLK_DIV(CDIV), .DEPTH(DEP), .HOLD_TICKS(HOLD), .REPEAT_TICKS(REP)
  ) dut (
    .clk(clk), .rst(rst), .i_btn(i_btn), .i_en(i_en),
    .o_level(o_level), .o_rise(o_rise), .o_fall(o_fall), .o_hold(o_hold), .o_tick(o_tick)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: samples tracked as the length of the current run of equal
  // values; hold pulses derived from ticks-since-rise arithmetic.
  bit             m_valid = 1'b0;
  int             m_en_cnt;
  logic [NCH-1:0] m_h1, m_h2, m_level, m_level_d, m_hold;
  bit             m_run_val[NCH];
  int             m_run_len[NCH];
  int             m_press[NCH];

  task automatic model_step();
    bit tk, s, rp, nl, nh;
    if (rst) begin
      m_en_cnt = 0;
      m_h1 = '0; m_h2 = '0; m_level = '0; m_level_d = '0; m_hold = '0;
      for (int ch = 0; ch < NCH; ch++) begin
        m_run_val[ch] = 1'b0;
        m_run_len[ch] = DEP;
        m_press[ch]   = -1;
      end
      m_valid = 1'b1;
      return;
    end
    if (!m_valid) return;
    tk = i_en && (m_en_cnt % CDIV == CDIV - 1);
    if (i_en) m_en_cnt++;
    for (int ch = 0; ch < NCH; ch++) begin
      s  = m_h2[ch];
      rp = m_level[ch] & ~m_level_d[ch];
      nl = (m_run_len[ch] >= DEP) ? m_run_val[ch] : m_level[ch];
      nh = 1'b0;
      if (!m_level[ch]) m_press[ch] = -1;
      else if (rp) m_press[ch] = 0;
      else if (tk && m_press[ch] >= 0) begin
        m_press[ch]++;
        nh = (m_press[ch] == HOLD) ||
             (REP > 0 && m_press[ch] > HOLD && (m_press[ch] - HOLD) % REP == 0);
      end
      if (tk) begin
        if (s == m_run_val[ch]) m_run_len[ch]++;
        else begin
          m_run_val[ch] = s;
          m_run_len[ch] = 1;
        end
      end
      m_level_d[ch] = m_level[ch];
      m_level[ch]   = nl;
      m_hold[ch]    = nh;
    end
    m_h2 = m_h1;
    m_h1 = i_btn;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  int d_rise[NCH], d_fall[NCH], d_hold[NCH], e_rise[NCH], e_fall[NCH], e_hold[NCH];
  int d_first_hold[NCH], d_last_hold[NCH];
  int d_ticks;

  task automatic clear_counts();
    for (int ch = 0; ch < NCH; ch++) begin
      d_rise[ch] = 0; d_fall[ch] = 0; d_hold[ch] = 0;
      e_rise[ch] = 0; e_fall[ch] = 0; e_hold[ch] = 0;
      d_first_hold[ch] = -1; d_last_hold[ch] = -1;
    end
    d_ticks = 0;
  endtask

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("tick",  {31'd0, o_tick}, {31'd0, !rst && i_en && (m_en_cnt % CDIV == CDIV - 1)});
      check("level", o_level, m_level);
      check("rise",  o_rise,  m_level & ~m_level_d);
      check("fall",  o_fall,  ~m_level & m_level_d);
      check("hold",  o_hold,  m_hold);
      if (o_tick) d_ticks++;
      for (int ch = 0; ch < NCH; ch++) begin
        if (o_rise[ch]) d_rise[ch]++;
        if (o_fall[ch]) d_fall[ch]++;
        if (o_hold[ch]) begin
          if (d_hold[ch] == 0) d_first_hold[ch] = cyc;
          d_last_hold[ch] = cyc;
          d_hold[ch]++;
        end
        if (m_level[ch] & ~m_level_d[ch]) e_rise[ch]++;
        if (~m_level[ch] & m_level_d[ch]) e_fall[ch]++;
        if (m_hold[ch]) e_hold[ch]++;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns just after the posedge on which a tick was consumed.
  task automatic align(output int t);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_tick !== 1'b1 && n < 3 * CDIV);
    if (o_tick !== 1'b1) begin
      total++; bad++;
      $display("FAIL align: no tick within %0d clk", 3 * CDIV);
    end
    @(posedge clk);
    #1;
    t = cyc;
  endtask

  task automatic wait_level(input int ch, input logic val, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_level[ch] === val) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      total++; bad++;
      $display("FAIL wait_level ch%0d: level %0b not seen within %0d clk", ch, val, budget);
    end
  endtask

  task automatic wait_hold(input int ch, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_hold[ch] === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      total++; bad++;
      $display("FAIL wait_hold ch%0d: no hold within %0d clk", ch, budget);
    end
  endtask

  initial begin
    int t, at, r;
    clear_counts();
    cycles(3);
    rst = 1'b0;
    @(negedge clk);
    check("reset_level", o_level, 0);
    check("reset_pulses", o_rise | o_fall | o_hold, 0);
    check("reset_tick", {31'd0, o_tick}, 0);

    // Clean press on ch0, tick cadence and latency.
    align(t);
    i_btn[0] = 1'b1;
    clear_counts();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("tick_period", {31'd0, o_tick}, {31'd0, (i % 4 == 3)});
    end
    wait_level(0, 1'b1, 40, at);
    check("press_latency", at - t, 17);
    cycles(30);
    check("press_rise_cnt", d_rise[0], 1);
    check("press_model_rise", e_rise[0], 1);
    check("press_fall_cnt", d_fall[0], 0);
    check("ch1_quiet", d_rise[1] + d_fall[1] + d_hold[1], 0);
    i_btn[0] = 1'b0;
    wait_level(0, 1'b0, 40, at);
    cycles(5);

    // Bounce on press, then bounce on release.
    clear_counts();
    for (int k = 0; k < 14; k++) begin
      i_btn[0] = (k % 2 == 0);
      cycles(3);
    end
    i_btn[0] = 1'b1;
    cycles(40);
    check("bounce_rise", d_rise[0], 1);
    check("bounce_nofall", d_fall[0], 0);
    check("bounce_model_rise", e_rise[0], 1);
    clear_counts();
    for (int k = 0; k < 14; k++) begin
      i_btn[0] = (k % 2 == 1);
      cycles(3);
    end
    i_btn[0] = 1'b0;
    cycles(40);
    check("bounce_fall", d_fall[0], 1);
    check("bounce_norise", d_rise[0], 0);
    check("bounce_model_fall", e_fall[0], 1);

    // Long press with auto-repeat on ch1: holds at 48, 64, ..., 400 clk.
    clear_counts();
    align(t);
    i_btn[1] = 1'b1;
    cycles(396);
    i_btn[1] = 1'b0;
    cycles(40);
    check("repeat_hold_cnt", d_hold[1], 23);
    check("repeat_model_hold", e_hold[1], 23);
    check("repeat_first_at", d_first_hold[1] - t, 48);
    check("repeat_last_at", d_last_hold[1] - t, 400);
    check("repeat_fall", d_fall[1], 1);
    check("repeat_ch0_quiet", d_hold[0] + d_rise[0], 0);

    // Level drops just before the 8th counted tick: no hold.
    clear_counts();
    align(t);
    i_btn[0] = 1'b1;
    cycles(29);
    i_btn[0] = 1'b0;
    cycles(40);
    check("thr_nohold", d_hold[0], 0);
    check("thr_model_nohold", e_hold[0], 0);
    check("thr_fall", d_fall[0], 1);

    // One tick later: the hold fires, counted afresh from IDLE.
    clear_counts();
    align(t);
    i_btn[0] = 1'b1;
    cycles(33);
    i_btn[0] = 1'b0;
    cycles(40);
    check("near_hold", d_hold[0], 1);
    check("near_hold_at", d_first_hold[0] - t, 48);

    // Reset while ch0 is high.
    clear_counts();
    i_btn[0] = 1'b1;
    wait_level(0, 1'b1, 40, at);
    cycles(3);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    r = cyc;
    @(negedge clk);
    check("midrst_level", o_level, 0);
    check("midrst_pulses", o_rise | o_fall | o_hold, 0);
    wait_level(0, 1'b1, 40, at);
    check("midrst_relatency", at - r, 17);
    check("midrst_nofall", d_fall[0], 0);
    check("midrst_rise", d_rise[0], 2);
    i_btn[0] = 1'b0;
    wait_level(0, 1'b0, 40, at);
    cycles(5);

    // Enable freeze of 20 clk during PRESS delays the hold by 20 clk.
    clear_counts();
    align(t);
    i_btn[1] = 1'b1;
    cycles(24);
    i_en = 1'b0;
    d_ticks = 0;
    cycles(20);
    check("freeze_noticks", d_ticks, 0);
    i_en = 1'b1;
    wait_hold(1, 80, at);
    check("freeze_hold_at", at - t, 68);
    i_btn[1] = 1'b0;
    cycles(40);
    check("freeze_fall", d_fall[1], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
